// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Run/pause/clear stopwatch with 1 s prescaler, BCD MM:SS counter
//             and lap-freeze of the displayed value.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
   parameter int DIV   = 24000,
   parameter int DIV_W = 25
) (
   input  logic       clk,
   input  logic       res,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       lap_hold,
   output logic       sec_pulse,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
   localparam logic [15:0]      c_max_time = 16'h5959;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_presc, w_presc_nxt;
   // Time words are packed {min_tens, min_ones, sec_tens, sec_ones}.
   logic [15:0]      r_live, w_live_nxt;
   logic [15:0]      r_latch, w_latch_nxt;
   logic             r_hold, w_hold_nxt;
   logic             w_tick, w_wrap;

   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [15:0] n;
      n = t;
      if (t[3:0] != 4'd9) begin
         n[3:0] = t[3:0] + 4'd1;
      end else begin
         n[3:0] = 4'd0;
         if (t[7:4] != 4'd5) begin
            n[7:4] = t[7:4] + 4'd1;
         end else begin
            n[7:4] = 4'd0;
            if (t[11:8] != 4'd9) begin
               n[11:8] = t[11:8] + 4'd1;
            end else begin
               n[11:8]  = 4'd0;
               n[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
            end
         end
      end
      return n;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_live_nxt  = r_live;
      w_latch_nxt = r_latch;
      w_hold_nxt  = r_hold;
      w_tick      = 1'b0;
      w_wrap      = 1'b0;
      case (r_state)
         IDLE: begin
            w_presc_nxt = '0;
            if (start_stop) w_state_nxt = RUN;
         end
         RUN: begin
            if (r_presc == c_div_last) begin
               w_presc_nxt = '0;
               w_tick      = 1'b1;
               w_wrap      = (r_live == c_max_time);
               w_live_nxt  = bcd_inc(r_live);
            end else begin
               w_presc_nxt = r_presc + DIV_W'(1);
            end
            // Lap samples the current (pre-increment) live value.
            if (lap) begin
               if (!r_hold) begin
                  w_latch_nxt = r_live;
                  w_hold_nxt  = 1'b1;
               end else begin
                  w_hold_nxt  = 1'b0;
               end
            end
            if (start_stop) w_state_nxt = PAUSE;
         end
         PAUSE: begin
            if (clear) begin
               w_state_nxt = IDLE;
               w_presc_nxt = '0;
               w_live_nxt  = '0;
               w_latch_nxt = '0;
               w_hold_nxt  = 1'b0;
            end else if (start_stop) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state values so they stay aligned
   // with the internal state without an extra cycle of lag.
   always_ff @(posedge clk) begin
      if (res) begin
         r_state   <= IDLE;
         r_presc   <= '0;
         r_live    <= '0;
         r_latch   <= '0;
         r_hold    <= 1'b0;
         {min_tens, min_ones, sec_tens, sec_ones} <= '0;
         running   <= 1'b0;
         lap_hold  <= 1'b0;
         sec_pulse <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_live    <= w_live_nxt;
         r_latch   <= w_latch_nxt;
         r_hold    <= w_hold_nxt;
         {min_tens, min_ones, sec_tens, sec_ones} <= w_hold_nxt ? w_latch_nxt : w_live_nxt;
         running   <= (w_state_nxt == RUN);
         lap_hold  <= w_hold_nxt;
         sec_pulse <= w_tick;
         overflow  <= w_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Self-checking bench for stopwatch_ctrl against a seconds-based
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

   localparam int c_div = 10;

   logic       clk;
   logic       res;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, lap_hold, sec_pulse, overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: elapsed time kept as plain seconds 0..3599.
   int m_mode = 0;   // 0 idle, 1 run, 2 pause
   int m_sub  = 0;
   int m_secs = 0;
   int m_lat  = 0;
   bit m_hold = 0;
   bit m_pulse = 0;
   bit m_ovf  = 0;

   stopwatch_ctrl #(.DIV(c_div), .DIV_W(4)) dut (
      .clk        (clk),
      .res        (res),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .sec_ones   (sec_ones),
      .sec_tens   (sec_tens),
      .min_ones   (min_ones),
      .min_tens   (min_tens),
      .running    (running),
      .lap_hold   (lap_hold),
      .sec_pulse  (sec_pulse),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [15:0] to_disp(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
   endfunction

   task automatic model(input bit r, input bit ss, input bit cl, input bit lp);
      m_pulse = 0;
      m_ovf   = 0;
      if (r) begin
         m_mode = 0; m_sub = 0; m_secs = 0; m_lat = 0; m_hold = 0;
      end else if (m_mode == 0) begin
         m_sub = 0;
         if (ss) m_mode = 1;
      end else if (m_mode == 1) begin
         if (lp) begin
            if (!m_hold) begin
               m_lat  = m_secs;
               m_hold = 1;
            end else begin
               m_hold = 0;
            end
         end
         if (m_sub == c_div - 1) begin
            m_sub   = 0;
            m_pulse = 1;
            m_ovf   = (m_secs == 3599);
            m_secs  = (m_secs + 1) % 3600;
         end else begin
            m_sub++;
         end
         if (ss) m_mode = 2;
      end else begin
         if (cl) begin
            m_mode = 0; m_sub = 0; m_secs = 0; m_lat = 0; m_hold = 0;
         end else if (ss) begin
            m_mode = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit ss, input bit cl, input bit lp);
      res = r; start_stop = ss; clear = cl; lap = lp;
      @(posedge clk);
      model(r, ss, cl, lp);
      #1;
      chk("display", {16'd0, min_tens, min_ones, sec_tens, sec_ones},
          {16'd0, to_disp(m_hold ? m_lat : m_secs)});
      chk("running",   {31'd0, running},   {31'd0, (m_mode == 1)});
      chk("lap_hold",  {31'd0, lap_hold},  {31'd0, m_hold});
      chk("sec_pulse", {31'd0, sec_pulse}, {31'd0, m_pulse});
      chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   initial begin
      res = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Basic counting through the first carry into sec_tens.
      step(0, 1, 0, 0);
      idle(105);

      // Partial-second pause/resume, clear ignored in RUN, clear in PAUSE.
      step(0, 1, 0, 0);
      idle(6);
      step(0, 1, 0, 0);
      idle(3);
      step(0, 1, 0, 0);
      idle(20);
      step(0, 1, 0, 0);
      idle(12);
      step(0, 0, 1, 0);
      idle(4);
      step(0, 1, 0, 0);
      idle(3);
      step(0, 0, 1, 0);
      idle(3);

      // Reset held three cycles mid-count, then restart.
      step(0, 1, 0, 0);
      idle(27);
      step(1, 1, 0, 1);
      step(1, 0, 1, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      idle(4);

      // Simultaneous keys: RUN -> PAUSE, then PAUSE -> IDLE.
      step(0, 1, 1, 0);
      idle(3);
      step(0, 1, 1, 0);
      idle(3);

      // Lap at 00:03, release at 00:07, then lap coincident with an increment.
      step(0, 1, 0, 0);
      idle(34);
      step(0, 0, 0, 1);
      idle(40);
      step(0, 0, 0, 1);
      idle(5);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      idle(9);
      step(0, 0, 0, 1);
      idle(12);
      step(0, 0, 0, 1);

      // Run through 59:59 -> 00:00 and keep counting past the wrap.
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      idle(36150);

      // Randomized key traffic.
      for (int i = 0; i < 8000; i++) begin
         step(($urandom_range(999) < 2),
              ($urandom_range(99) < 6),
              ($urandom_range(99) < 4),
              ($urandom_range(99) < 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
